// File: rtl/reg_pipe_pkg.sv
// Shared limits and defaults for the reg_pipe valid/ready register pipeline.
package reg_pipe_pkg;

    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned DEPTH_MAX = 16;

    localparam logic [WIDTH_MAX-1:0] RESET_VAL_DEFAULT = '0;

endpackage : reg_pipe_pkg

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: valid bit, load-enabled data register and stage ready.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             flush_i,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready_c
);

    // A stage can take new data if it is empty or its contents move on this cycle.
    assign ready_c = !valid || next_ready;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            valid <= 1'b0;
        end else if (flush_i) begin
            valid <= 1'b0;
        end else if (ready_c) begin
            valid <= src_valid;
        end
    end

    // Data only moves with a real word, so bubbles and flushes leave it untouched.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            data <= RESET_VAL;
        end else if (ready_c && src_valid && !flush_i) begin
            data <= src_data;
        end
    end

endmodule : reg_pipe_stage

// File: rtl/reg_pipe.sv
// Valid/ready register pipeline of DEPTH stages with bubble collapse and flush.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
    input  logic                       clk_i,
    input  logic                       nrst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (WIDTH == 0 || WIDTH > WIDTH_MAX || DEPTH == 0 || DEPTH > DEPTH_MAX) begin : g_param_check
        $error("reg_pipe: WIDTH or DEPTH outside supported range");
    end

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [OCC_W-1:0] occ;

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             nxt_rdy;
        logic             stg_rdy;

        if (k == 0) begin : g_src_in
            assign src_valid = in_valid_i;
            assign src_data  = in_data_i;
        end else begin : g_src_prev
            assign src_valid = valid_q[k-1];
            assign src_data  = data_q[k-1];
        end

        // Ready ripples from the output side back towards the input.
        if (k == int'(DEPTH) - 1) begin : g_last
            assign nxt_rdy = out_ready_i;
        end else begin : g_mid
            assign nxt_rdy = g_stage[k+1].stg_rdy;
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk_i      (clk_i),
            .nrst_i     (nrst_i),
            .flush_i    (flush_i),
            .src_valid  (src_valid),
            .src_data   (src_data),
            .next_ready (nxt_rdy),
            .valid      (valid_q[k]),
            .data       (data_q[k]),
            .ready_c    (stg_rdy)
        );
    end

    // Population count of the registered valid bits.
    always_comb begin
        occ = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ = OCC_W'(occ + OCC_W'(valid_q[k]));
        end
    end

    assign in_ready_o  = g_stage[0].stg_rdy && !flush_i;
    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
    assign occupancy_o = occ;

endmodule : reg_pipe

// File: tb/tb_reg_pipe.sv
// Randomised and directed bench for reg_pipe (DEPTH=4 and DEPTH=1) against a position-list model.
module tb_reg_pipe;

    logic       clk_i;
    logic       nrst_i;
    logic       flush_i;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       out_ready_i;

    logic       in_ready4, out_valid4;
    logic [7:0] out_data4;
    logic [2:0] occ4;
    logic       in_ready1, out_valid1;
    logic [7:0] out_data1;
    logic [0:0] occ1;

    reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready4),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data4),
        .occupancy_o (occ4)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready1),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data1),
        .occupancy_o (occ1)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: words in arrival order, each with its stage position; out_data is the
    // last word that ever reached the final position.
    int         m_depth;
    logic [7:0] mq_d[$];
    int         mq_p[$];
    logic [7:0] m_last;

    function automatic void m_reset();
        mq_d.delete();
        mq_p.delete();
        m_last = 8'h00;
    endfunction

    function automatic int m_occ();
        return mq_d.size();
    endfunction

    function automatic bit m_out_valid();
        return (mq_d.size() > 0) && (mq_p[0] == m_depth - 1);
    endfunction

    function automatic bit m_in_ready(input bit fl, input bit orr);
        return !fl && ((mq_d.size() < m_depth) || orr);
    endfunction

    function automatic void m_update(input bit fl, input bit iv, input logic [7:0] id, input bit orr);
        bit acc;
        int limit;
        int np;
        if (fl) begin
            mq_d.delete();
            mq_p.delete();
            return;
        end
        acc = iv && m_in_ready(fl, orr);
        if (orr && m_out_valid()) begin
            void'(mq_d.pop_front());
            void'(mq_p.pop_front());
        end
        limit = m_depth - 1;
        for (int i = 0; i < mq_d.size(); i++) begin
            np = (mq_p[i] + 1 < limit) ? mq_p[i] + 1 : limit;
            if (np == m_depth - 1 && mq_p[i] != m_depth - 1) m_last = mq_d[i];
            mq_p[i] = np;
            limit = np - 1;
        end
        if (acc) begin
            mq_d.push_back(id);
            mq_p.push_back(0);
            if (m_depth == 1) m_last = id;
        end
    endfunction

    bit         sel;
    int         cyc = 0;
    int         last_cyc;
    bit         last_acc;
    bit         o_in_ready, o_valid;
    int         o_occ;
    logic [7:0] o_data;
    logic [7:0] delivered[$];

    // One clock: check outputs against the model, then advance both across the edge.
    task automatic cycle();
        bit mir;
        #1;
        o_in_ready = sel ? in_ready1  : in_ready4;
        o_valid    = sel ? out_valid1 : out_valid4;
        o_data     = sel ? out_data1  : out_data4;
        o_occ      = sel ? int'(occ1) : int'(occ4);
        mir = m_in_ready(flush_i, out_ready_i);
        chk("in_ready",  int'(o_in_ready), int'(mir));
        chk("out_valid", int'(o_valid),    int'(m_out_valid()));
        chk("occupancy", o_occ,            m_occ());
        chk("out_data",  int'(o_data),     int'(m_last));
        last_acc = in_valid_i && mir;
        if (o_valid && out_ready_i) delivered.push_back(o_data);
        last_cyc = cyc;
        @(posedge clk_i);
        m_update(flush_i, in_valid_i, in_data_i, out_ready_i);
        cyc++;
        @(negedge clk_i);
    endtask

    // Async reset pulse placed between edges; returns aligned to the next falling edge.
    task automatic reset_pulse(input string tag);
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        #2 nrst_i = 1'b0;
        #1;
        chk({tag, "_valid"}, int'(sel ? out_valid1 : out_valid4), 0);
        chk({tag, "_data"},  int'(sel ? out_data1 : out_data4), 0);
        chk({tag, "_occ"},   sel ? int'(occ1) : int'(occ4), 0);
        chk({tag, "_rdy"},   int'(sel ? in_ready1 : in_ready4), 1);
        m_reset();
        #1 nrst_i = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        int idx;
        int t_acc;
        int t_out;
        nrst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; out_ready_i = 1'b0;
        sel = 1'b0; m_depth = 4; m_reset();
        #3;
        chk("rst_valid", int'(out_valid4), 0);
        chk("rst_occ",   int'(occ4), 0);
        chk("rst_data",  int'(out_data4), 0);
        chk("rst_rdy",   int'(in_ready4), 1);
        flush_i = 1'b1;
        #1 chk("rst_rdy_flush", int'(in_ready4), 0);
        flush_i = 1'b0;
        @(negedge clk_i);
        nrst_i = 1'b1;

        // Streaming 0x01..0x08 with out_ready high.
        out_ready_i = 1'b1; delivered.delete();
        idx = 0; t_acc = -1; t_out = -1;
        for (int c = 0; c < 20; c++) begin
            in_valid_i = (idx < 8);
            in_data_i  = 8'(idx + 1);
            cycle();
            if (last_acc && idx == 0) t_acc = last_cyc;
            if (o_valid && o_data == 8'h01 && t_out < 0) t_out = last_cyc;
            if (c == 6) chk("stream_occ", o_occ, 4);
            if (last_acc) idx++;
        end
        chk("stream_latency", t_out - t_acc, 4);
        chk("stream_count", delivered.size(), 8);
        for (int i = 0; i < 8 && i < delivered.size(); i++) chk("stream_order", int'(delivered[i]), i + 1);

        // Backpressure fill then drain.
        out_ready_i = 1'b0; delivered.delete(); idx = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 10) begin
                chk("bp_accepted", idx, 4);
                chk("bp_occ", o_occ, 4);
                chk("bp_rdy", int'(o_in_ready), 0);
                out_ready_i = 1'b1;
            end
            in_valid_i = (idx < 6);
            in_data_i  = 8'hA0 + 8'(idx);
            cycle();
            if (last_acc) idx++;
        end
        chk("bp_count", delivered.size(), 6);
        for (int i = 0; i < 6 && i < delivered.size(); i++) chk("bp_order", int'(delivered[i]), 'hA0 + i);

        // Bubble collapse under backpressure.
        out_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid_i = (c == 0) || (c == 3);
            in_data_i  = (c == 0) ? 8'h11 : 8'h22;
            cycle();
            chk("bubble_rdy", int'(o_in_ready), 1);
        end
        chk("bubble_occ", o_occ, 2);
        chk("bubble_head", int'(o_data), 'h11);
        in_valid_i = 1'b0; flush_i = 1'b1; cycle(); flush_i = 1'b0;

        // Flush with a colliding input word.
        delivered.delete();
        for (int c = 0; c < 6; c++) begin
            in_valid_i = (c < 3);
            in_data_i  = 8'h31 + 8'(c);
            cycle();
        end
        chk("flush_pre_occ", o_occ, 3);
        flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h55;
        cycle();
        chk("flush_rdy", int'(o_in_ready), 0);
        flush_i = 1'b0; in_valid_i = 1'b0;
        cycle();
        chk("flush_occ", o_occ, 0);
        chk("flush_valid", int'(o_valid), 0);
        out_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) cycle();
        chk("flush_none_out", delivered.size(), 0);

        // Async reset with a full pipe, then latency after release.
        out_ready_i = 1'b0; idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid_i = (idx < 4);
            in_data_i  = 8'h41 + 8'(idx);
            cycle();
            if (last_acc) idx++;
        end
        chk("arst_pre_occ", o_occ, 4);
        reset_pulse("arst");
        out_ready_i = 1'b1; t_acc = -1; t_out = -1; idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid_i = (idx < 1);
            in_data_i  = 8'h77;
            cycle();
            if (last_acc && idx == 0) t_acc = last_cyc;
            if (o_valid && o_data == 8'h77 && t_out < 0) t_out = last_cyc;
            if (last_acc) idx++;
        end
        chk("arst_latency", t_out - t_acc, 4);

        // Random traffic, DEPTH=4.
        for (int c = 0; c < 400; c++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = 8'($urandom);
            out_ready_i = ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush_i = 1'b0;

        // DEPTH=1 instance: alternate out_ready while streaming 0x01..0x04.
        sel = 1'b1; m_depth = 1;
        reset_pulse("arst1");
        delivered.delete(); idx = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready_i = (c % 2 == 0);
            in_valid_i  = (idx < 4);
            in_data_i   = 8'(idx + 1);
            cycle();
            if (last_acc) idx++;
        end
        out_ready_i = 1'b1; in_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        chk("d1_count", delivered.size(), 4);
        for (int i = 0; i < 4 && i < delivered.size(); i++) chk("d1_order", int'(delivered[i]), i + 1);

        for (int c = 0; c < 200; c++) begin
            in_valid_i  = ($urandom_range(0, 1) != 0);
            in_data_i   = 8'($urandom);
            out_ready_i = ($urandom_range(0, 1) != 0);
            flush_i     = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_pipe

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, legal range 1..16.
REQ-003 SHALL have parameter RESET_VAL, default 0: value of each stage data register after reset, WIDTH bits.
REQ-004 SHALL have port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1 bit: synchronous discard of all pipeline contents.
REQ-007 SHALL have port in_valid_i, input, 1 bit: upstream data valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit: pipe accepts in_data_i this cycle.
REQ-009 SHALL have port in_data_i, input, WIDTH bits: upstream data.
REQ-010 SHALL have port out_valid_o, output, 1 bit: last stage holds valid data.
REQ-011 SHALL have port out_ready_i, input, 1 bit: downstream accepts out_data_o this cycle.
REQ-012 SHALL have port out_data_o, output, WIDTH bits: data of the last stage.
REQ-013 SHALL have port occupancy_o, output, $clog2(DEPTH+1) bits: count of valid stages.

Function
REQ-014 Stage k (0 = input side, DEPTH-1 = output side) SHALL hold one valid bit v[k] and one data register d[k].
REQ-015 Stage ready SHALL be r[DEPTH-1] = !v[DEPTH-1] || out_ready_i, and r[k] = !v[k] || r[k+1] for k < DEPTH-1 (bubble collapse, combinational chain).
REQ-016 in_ready_o SHALL equal r[0] && !flush_i.
REQ-017 Transfer in SHALL occur when in_valid_i && in_ready_o; transfer out SHALL occur when out_valid_o && out_ready_i.
REQ-018 When r[k] = 1, stage k SHALL load v[k] <= source valid and d[k] <= source data. Source is in_valid_i/in_data_i for k = 0 and v[k-1]/d[k-1] otherwise.
REQ-019 d[k] SHALL hold its value whenever r[k] = 0, or when the source valid is 0 (no data-register toggling on bubbles).
REQ-020 Latency SHALL be DEPTH cycles from an input transfer to out_valid_o for that word, given no stalls.
REQ-021 Throughput SHALL be one word per cycle while out_ready_i = 1.
REQ-022 Word order SHALL be preserved; no word is duplicated or lost except by flush_i or reset.
REQ-023 When v[DEPTH-1] = 0 and out_ready_i = 0, the pipe SHALL still accept until all DEPTH stages are valid (full).
REQ-024 When full and out_ready_i = 0, in_ready_o SHALL be 0 and all stages SHALL hold.
REQ-025 When full and out_ready_i = 1, one word SHALL leave, one SHALL enter, and every stage SHALL advance in the same cycle.
REQ-026 flush_i = 1 SHALL clear all v[k] at the next edge. Flush has priority over any transfer in that cycle.
REQ-027 d[k] SHALL be unchanged by flush_i.
REQ-028 out_valid_o SHALL equal v[DEPTH-1]; out_data_o SHALL equal d[DEPTH-1] and hold its last value while invalid.
REQ-029 occupancy_o SHALL equal the population count of v[], combinationally from the registered v[] (0..DEPTH).
REQ-030 DEPTH = 1 SHALL behave as a single valid/ready register with the same rules.

Reset
REQ-031 nrst_i = 0 SHALL asynchronously force all v[k] = 0 and all d[k] = RESET_VAL, independent of clk_i.
REQ-032 During reset, out_valid_o SHALL be 0, occupancy_o 0, out_data_o RESET_VAL, and in_ready_o = !flush_i.
REQ-033 Reset deassertion mid-transfer SHALL leave the pipe empty; the first accepted word after release SHALL appear after DEPTH cycles.

Structure
REQ-034 The shared package SHALL define the parameter-range limits (WIDTH_MAX = 64, DEPTH_MAX = 16) and the default RESET_VAL.
REQ-035 One sub-module, reg_pipe_stage, SHALL implement a single stage: valid bit, WIDTH-bit data register with load enable, and ready computation. reg_pipe SHALL instantiate it DEPTH times via generate.
REQ-036 reg_pipe SHALL contain no latches, no combinational loop beyond the ready chain, and a single clock domain.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-037 Streaming: send 0x01..0x08 back-to-back with out_ready_i=1 -> 0x01 appears 4 cycles after its acceptance, then one word per cycle in order, occupancy_o steady at 4.
REQ-038 Backpressure fill: out_ready_i=0, send 0xA0..0xA5 -> 0xA0..0xA3 accepted, in_ready_o=0 thereafter, occupancy_o=4; raise out_ready_i -> 0xA0..0xA5 delivered in order, none lost.
REQ-039 Bubble collapse: send 0x11, idle 2 cycles, send 0x22, with out_ready_i=0 -> both words pack into stages 3 and 2, occupancy_o=2, in_ready_o stays 1.
REQ-040 Flush: with occupancy_o=3, assert flush_i together with in_valid_i and 0x55 for 1 cycle -> in_ready_o=0 that cycle, next cycle occupancy_o=0 and out_valid_o=0, 0x55 never emerges.
REQ-041 Async reset: with occupancy_o=4, pulse nrst_i low between clock edges -> out_valid_o=0, out_data_o=0x00, occupancy_o=0 immediately; after release, a word sent is delivered 4 cycles after acceptance.
REQ-042 DEPTH=1 regression: alternate out_ready_i 1/0 while streaming 0x01..0x04 -> all four words delivered in order, in_ready_o=0 only when the stage is full and out_ready_i=0.
